// File: rtl/ffo_req_serializer_if.sv
// Request/grant bundle between the request collector, the serializer and the
// per-channel service logic.
interface ffo_req_serializer_if #(
    parameter int WIDTH = 4
);
    localparam int IDXW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_onehot;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_onehot, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_onehot, out_idx, out_last, busy
    );
endinterface

// File: rtl/ffo_req_serializer.sv
// Serializes a request vector into one grant per set bit, lowest index first,
// presenting each grant as a one-hot vector plus its binary index.
module ffo_req_serializer #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ffo_req_serializer_if.slave   bus
);
    localparam int IDXW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [WIDTH-1:0] lowbit;
    logic [IDXW-1:0]  idx;
    logic             emit;
    logic             last;
    logic             in_ready;
    logic             load;

    always_comb begin
        lowbit    = pending_q & (~pending_q + WIDTH'(1));
        pending_d = pending_q & ~lowbit;
        last      = (pending_d == '0);
        idx       = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (lowbit[i]) idx = IDXW'(i);
        end
        // Outputs are forced quiet while rst is high, before the reset edge lands.
        emit     = !rst && (state_q == EMIT);
        in_ready = !rst && ((state_q == IDLE) || (emit && last && bus.out_ready));
        load     = bus.in_valid && in_ready && (bus.in_vec != '0);
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = emit;
    assign bus.busy       = emit;
    assign bus.out_onehot = emit ? lowbit : '0;
    assign bus.out_idx    = emit ? idx : '0;
    assign bus.out_last   = emit && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        pending_q <= bus.in_vec;
                        state_q   <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (!last) begin
                            pending_q <= pending_d;
                        end else if (load) begin
                            pending_q <= bus.in_vec;
                        end else begin
                            pending_q <= '0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: begin
                    pending_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ffo_req_serializer.sv
// Scoreboard bench for ffo_req_serializer at WIDTH=4.
module tb_ffo_req_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ffo_req_serializer_if #(.WIDTH(4)) bus ();

    ffo_req_serializer #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] oh;
        logic [1:0] idx;
        logic       last;
        logic [3:0] vec;
    } grant_t;

    grant_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    // Expected grant list: every set bit, ascending, last when no higher bit remains.
    function automatic void push_vec(input logic [3:0] v);
        grant_t g;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                g.oh   = 4'b0001 << i;
                g.idx  = i[1:0];
                g.last = ((v >> (i + 1)) == 4'd0);
                g.vec  = v;
                sb.push_back(g);
            end
        end
    endfunction

    task automatic step(input logic rs, input logic iv, input logic [3:0] v, input logic r);
        @(negedge clk);
        rst           = rs;
        bus.in_valid  = iv;
        bus.in_vec    = v;
        bus.out_ready = r;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 4'd0, 1'b0);
            n_cmp++;
            if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_onehot, bus.out_idx, bus.out_last} !== 9'd0)
                begin n_err++; $display("FAIL por_outputs: got %b want 0", {bus.in_ready, bus.out_valid, bus.busy, bus.out_onehot, bus.out_idx, bus.out_last}); end
        end
        step(1'b0, 1'b0, 4'd0, 1'b0);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin n_err++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
        step(1'b0, 1'b1, 4'b1010, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_onehot !== 4'b0010)
            begin n_err++; $display("FAIL held_1010: valid=%b onehot=%b want 1/0010", bus.out_valid, bus.out_onehot); end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 4'd0, 1'b1);
            n_cmp++;
            if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_onehot, bus.out_idx, bus.out_last} !== 9'd0)
                begin n_err++; $display("FAIL midrst_outputs: got %b want 0", {bus.in_ready, bus.out_valid, bus.busy, bus.out_onehot, bus.out_idx, bus.out_last}); end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 4'd0, 1'b1);
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
                begin n_err++; $display("FAIL discard_1010: valid=%b busy=%b in_ready=%b want 0/0/1", bus.out_valid, bus.busy, bus.in_ready); end
        end
    endtask

    task automatic test_multi_bit();
        grant_t e;
        int seen = 0;
        step(1'b0, 1'b1, 4'b1011, 1'b1);
        push_vec(4'b1011);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 4'd0, 1'b1);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
                n_err++; $display("FAIL multi_valid: cycle %0d valid=%b want 1", c, bus.out_valid);
            end else begin
                e = sb.pop_front(); seen++;
                if ({bus.out_onehot, bus.out_idx, bus.out_last} !== {e.oh, e.idx, e.last})
                    begin n_err++; $display("FAIL multi_grant: got %b/%0d/%b want %b/%0d/%b", bus.out_onehot, bus.out_idx, bus.out_last, e.oh, e.idx, e.last); end
            end
        end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || seen != 3)
            begin n_err++; $display("FAIL multi_idle: busy=%b in_ready=%b grants=%0d want 0/1/3", bus.busy, bus.in_ready, seen); end
        sb.delete();
    endtask

    task automatic test_zero_vec();
        step(1'b0, 1'b1, 4'b0000, 1'b1);
        n_cmp++;
        if (bus.in_ready !== 1'b1)
            begin n_err++; $display("FAIL zero_accept: in_ready=%b want 1", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 4'd0, 1'b1);
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
                begin n_err++; $display("FAIL zero_idle: valid=%b busy=%b in_ready=%b want 0/0/1", bus.out_valid, bus.busy, bus.in_ready); end
        end
    endtask

    task automatic test_stall();
        grant_t e;
        int cyc = 0;
        step(1'b0, 1'b1, 4'b0110, 1'b0);
        push_vec(4'b0110);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'b1111, 1'b0);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.out_onehot, bus.out_idx, bus.out_last} !== {sb[0].oh, sb[0].idx, sb[0].last})
                begin n_err++; $display("FAIL stall_hold: valid=%b in_ready=%b got %b/%0d/%b want %b/%0d/%b", bus.out_valid, bus.in_ready, bus.out_onehot, bus.out_idx, bus.out_last, sb[0].oh, sb[0].idx, sb[0].last); end
        end
        while (sb.size() != 0 && cyc < 10) begin
            step(1'b0, 1'b0, 4'd0, 1'b1);
            cyc++;
            if (bus.out_valid) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.out_onehot, bus.out_idx, bus.out_last} !== {e.oh, e.idx, e.last})
                    begin n_err++; $display("FAIL stall_grant: got %b/%0d/%b want %b/%0d/%b", bus.out_onehot, bus.out_idx, bus.out_last, e.oh, e.idx, e.last); end
            end
        end
        n_cmp++;
        if (sb.size() != 0)
            begin n_err++; $display("FAIL stall_timeout: %0d grants missing, want 0", sb.size()); sb.delete(); end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b0)
            begin n_err++; $display("FAIL stall_extra: valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        grant_t e;
        step(1'b0, 1'b1, 4'b1000, 1'b1);
        push_vec(4'b1000);
        step(1'b0, 1'b1, 4'b0011, 1'b1);
        n_cmp++;
        if (bus.in_ready !== 1'b1)
            begin n_err++; $display("FAIL b2b_ready: in_ready=%b want 1", bus.in_ready); end
        if (bus.in_ready) push_vec(4'b0011);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step(1'b0, 1'b0, 4'd0, 1'b1);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
                n_err++; $display("FAIL b2b_gap: cycle %0d valid=%b want 1", c, bus.out_valid);
            end else begin
                e = sb.pop_front();
                if ({bus.out_onehot, bus.out_idx, bus.out_last} !== {e.oh, e.idx, e.last})
                    begin n_err++; $display("FAIL b2b_grant: got %b/%0d/%b want %b/%0d/%b", bus.out_onehot, bus.out_idx, bus.out_last, e.oh, e.idx, e.last); end
            end
        end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        n_cmp++;
        if (bus.busy !== 1'b0)
            begin n_err++; $display("FAIL b2b_idle: busy=%b want 0", bus.busy); end
        sb.delete();
    endtask

    task automatic test_sweep();
        grant_t e;
        int v = 0;
        int cyc = 0;
        int prev = -1;
        logic [3:0] acc = 4'd0;
        logic r;
        while ((v < 16 || sb.size() != 0) && cyc < 2000) begin
            r = 1'($urandom_range(0, 1));
            step(1'b0, (v < 16), v[3:0], r);
            cyc++;
            n_cmp++;
            if (bus.out_valid ? !$onehot(bus.out_onehot) : (bus.out_onehot !== 4'd0))
                begin n_err++; $display("FAIL sweep_onehot0: valid=%b onehot=%b", bus.out_valid, bus.out_onehot); end
            if (bus.out_valid && r) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL sweep_extra: got %b want no grant", bus.out_onehot);
                end else begin
                    e = sb.pop_front();
                    if ({bus.out_onehot, bus.out_idx, bus.out_last} !== {e.oh, e.idx, e.last})
                        begin n_err++; $display("FAIL sweep_grant: vec %b got %b/%0d/%b want %b/%0d/%b", e.vec, bus.out_onehot, bus.out_idx, bus.out_last, e.oh, e.idx, e.last); end
                    if (acc == 4'd0 && e.vec[0]) begin
                        n_cmp++;
                        if (bus.out_onehot !== 4'b0001)
                            begin n_err++; $display("FAIL sweep_odd_first: vec %b got %b want 0001", e.vec, bus.out_onehot); end
                    end
                    if (acc != 4'd0) begin
                        n_cmp++;
                        if (int'(bus.out_idx) <= prev)
                            begin n_err++; $display("FAIL sweep_order: vec %b idx %0d want > %0d", e.vec, bus.out_idx, prev); end
                    end
                    acc  = acc | bus.out_onehot;
                    prev = int'(bus.out_idx);
                    if (bus.out_last) begin
                        n_cmp++;
                        if (acc !== e.vec)
                            begin n_err++; $display("FAIL sweep_or: got %b want %b", acc, e.vec); end
                        acc  = 4'd0;
                        prev = -1;
                    end
                end
            end
            if (v < 16 && bus.in_ready) begin
                push_vec(v[3:0]);
                v++;
            end
        end
        n_cmp++;
        if (cyc >= 2000)
            begin n_err++; $display("FAIL sweep_timeout: v=%0d pending=%0d want 16/0", v, sb.size()); sb.delete(); end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        n_cmp++;
        if (bus.busy !== 1'b0)
            begin n_err++; $display("FAIL sweep_idle: busy=%b want 0", bus.busy); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_vec    = 4'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_multi_bit();
        test_zero_vec();
        test_stall();
        test_back_to_back();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
